// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PLUS_A,
        PLUS_2A,
        MINUS_A,
        MINUS_2A
    } booth_sel_e;

endpackage

// File: rtl/booth_radix4_sel.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> signed addend of 0/+-A/+-2A.
module booth_radix4_sel
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [2:0]       window_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH+1:0] addend_o
);

    booth_sel_e       sel;
    logic [WIDTH+1:0] mcandExt;

    assign mcandExt = {{2{mcand_i[WIDTH-1]}}, mcand_i};

    always_comb begin
        sel = ZERO;
        case (window_i)
            3'b001, 3'b010: sel = PLUS_A;
            3'b011:         sel = PLUS_2A;
            3'b100:         sel = MINUS_2A;
            3'b101, 3'b110: sel = MINUS_A;
            default:        sel = ZERO;
        endcase
    end

    // Two guard bits keep +-2A exact for the most negative multiplicand.
    always_comb begin
        addend_o = '0;
        case (sel)
            PLUS_A:   addend_o = mcandExt;
            PLUS_2A:  addend_o = mcandExt << 1;
            MINUS_A:  addend_o = -mcandExt;
            MINUS_2A: addend_o = -(mcandExt << 1);
            default:  addend_o = '0;
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Define MULTDIV_EARLY_OUT_EN to finish zero-operand cases right after the start edge.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int MULT_CYCLES = WIDTH / 2;
    localparam int DIV_CYCLES  = WIDTH;
    localparam int CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH+1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic             xBit_q, xBit_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             negQuot_q, negQuot_d;
    logic             divZero_q, divZero_d;
    logic             divOvf_q, divOvf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH+1:0] boothAddend, boothSum, multHi;
    logic [WIDTH-1:0] multLo;
    logic             multX, multOvf;
    logic [WIDTH:0]   prodUpper;
    logic [WIDTH+1:0] divisorExt, remShift, remNext;
    logic [WIDTH-1:0] quotNext, quotSigned, absA, absB;
    logic             quotBit, startMult, startDiv;

    booth_radix4_sel #(
        .WIDTH(WIDTH)
    ) u_booth (
        .window_i({accLo_q[1:0], xBit_q}),
        .mcand_i (operand_q),
        .addend_o(boothAddend)
    );

    // Multiply step: {accHi, accLo, xBit} holds the partial product with the
    // multiplier shifting out of accLo; add then arithmetic-shift right by 2.
    assign boothSum  = accHi_q + boothAddend;
    assign multHi    = {{2{boothSum[WIDTH+1]}}, boothSum[WIDTH+1:2]};
    assign multLo    = {boothSum[1:0], accLo_q[WIDTH-1:2]};
    assign multX     = accLo_q[1];
    assign prodUpper = {multHi[WIDTH-1:0], multLo[WIDTH-1]};
    assign multOvf   = !((&prodUpper) || !(|prodUpper));

    // Divide step: accHi is the signed partial remainder, accLo shifts the
    // dividend magnitude out and quotient bits in.
    assign divisorExt = {2'b00, operand_q};
    assign remShift   = {accHi_q[WIDTH:0], accLo_q[WIDTH-1]};
    assign remNext    = accHi_q[WIDTH+1] ? remShift + divisorExt : remShift - divisorExt;
    assign quotBit    = ~remNext[WIDTH+1];
    assign quotNext   = {accLo_q[WIDTH-2:0], quotBit};
    assign quotSigned = negQuot_q ? -accLo_q : accLo_q;

    assign absA      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign absB      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign startMult = ctrl_MULT;
    assign startDiv  = ctrl_DIV && !ctrl_MULT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        xBit_d    = xBit_q;
        operand_d = operand_q;
        negQuot_d = negQuot_q;
        divZero_d = divZero_q;
        divOvf_d  = divOvf_q;
        result_d  = result_q;
        exc_d     = exc_q;

        case (state_q)
            MULT: begin
                accHi_d = multHi;
                accLo_d = multLo;
                xBit_d  = multX;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == MULT_LAST) begin
                    result_d = multLo;
                    exc_d    = multOvf;
                    state_d  = DONE;
                end
            end
            DIV: begin
                accHi_d = remNext;
                accLo_d = quotNext;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = divZero_q ? '0 : quotSigned;
                exc_d    = divZero_q || divOvf_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new start always wins, abandoning whatever is in flight.
        if (startMult) begin
            accHi_d   = '0;
            accLo_d   = data_operandB;
            xBit_d    = 1'b0;
            operand_d = data_operandA;
            cnt_d     = '0;
            state_d   = MULT;
`ifdef MULTDIV_EARLY_OUT_EN
            if (data_operandA == '0 || data_operandB == '0) begin
                result_d = '0;
                exc_d    = 1'b0;
                state_d  = DONE;
            end
`endif
        end else if (startDiv) begin
            accHi_d   = '0;
            accLo_d   = absA;
            operand_d = absB;
            negQuot_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divZero_d = (data_operandB == '0);
            divOvf_d  = (data_operandA == MIN_VAL) && (&data_operandB);
            cnt_d     = '0;
            state_d   = DIV;
`ifdef MULTDIV_EARLY_OUT_EN
            if (data_operandB == '0) begin
                result_d = '0;
                exc_d    = 1'b1;
                state_d  = DONE;
            end else if (data_operandA == '0) begin
                result_d = '0;
                exc_d    = 1'b0;
                state_d  = DONE;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            xBit_q    <= 1'b0;
            operand_q <= '0;
            negQuot_q <= 1'b0;
            divZero_q <= 1'b0;
            divOvf_q  <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            xBit_q    <= xBit_d;
            operand_q <= operand_d;
            negQuot_q <= negQuot_d;
            divZero_q <= divZero_d;
            divOvf_q  <= divOvf_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);

endmodule
